// File: rtl/game_pkg.sv
// Shared definitions for the block/obstacle game: state encoding, screen bounds,
// obstacle geometry and the colour palette used by the pixel/colour logic.
// No logic of its own; imported by the sequencer and the spawn generator.
package game_pkg;

   // Round state encoding, also driven out on the sequencer's state port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   // Visible window in raw hCount/vCount units.
   localparam int unsigned H_MIN = 144;
   localparam int unsigned H_MAX = 783;
   localparam int unsigned V_MIN = 35;
   localparam int unsigned V_MAX = 515;

   // Obstacle geometry. The spawn window keeps the whole obstacle on screen:
   // centre x lies in [H_MIN+OBS_HALF_W, H_MIN+OBS_HALF_W+SPAWN_RANGE-1].
   localparam int unsigned OBS_HALF_W  = 120;
   localparam int unsigned SPAWN_BASE  = H_MIN + OBS_HALF_W;
   localparam int unsigned SPAWN_RANGE = (H_MAX - H_MIN + 1) - 2 * OBS_HALF_W;

   // Obstacle parks at the horizontal screen centre out of reset.
   localparam logic [9:0] X_RESET = 10'((H_MIN + H_MAX) / 2);

   // 12-bit RGB palette shared with the colour logic.
   localparam logic [11:0] COL_BG    = 12'h000;
   localparam logic [11:0] COL_BLOCK = 12'h0F0;
   localparam logic [11:0] COL_OBS   = 12'hF00;
   localparam logic [11:0] COL_FLASH = 12'hFF0;

endpackage

// File: rtl/obs_spawn_lfsr.sv
// Purpose: 10-bit Galois LFSR (x^10+x^7+1) mapped to an on-screen obstacle spawn x.
// Latency: LFSR steps one cycle after adv; spawn_x follows the current LFSR state combinationally.
// Backpressure: none; adv is a free-running pulse and is never refused.
// Ports: clk, rst (sync, active high), adv (step the LFSR), spawn_x (obstacle centre x candidate).
module obs_spawn_lfsr
   import game_pkg::*;
#(
   parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
   output logic [9:0] spawn_x
);

   // Right-shifting Galois form: the bit shifted out toggles bits 9 and 6.
   localparam logic [9:0] TAPS = 10'h240;
   localparam logic [8:0] RANGE = 9'(SPAWN_RANGE);

   logic [9:0] lfsr;
   logic [8:0] c;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (adv) begin
         lfsr <= {1'b0, lfsr[9:1]} ^ (lfsr[0] ? TAPS : 10'd0);
      end
   end

   // Low 9 bits span 0..511; one conditional subtract folds them into 0..RANGE-1.
   always_comb begin
      c = lfsr[8:0];
      if (c >= RANGE) begin
         c = c - RANGE;
      end
   end

   assign spawn_x = 10'(SPAWN_BASE) + {1'b0, c};

endmodule

// File: rtl/game_sequencer.sv
// Purpose: round controller - obstacle fall/respawn/speed ramp, collision, score, lives, move gating.
// Latency: every output is registered and reflects the causing edge one cycle later.
// Backpressure: none; frame_tick/start/pixel_overlap are sampled every cycle, never stalled.
// Ports: clk, rst (sync, active high), frame_tick, start, pixel_overlap in;
//        xpos_obs/ypos_obs (obstacle centre), move_en, score, lives, state, flash out.
module game_sequencer
   import game_pkg::*;
#(
   parameter int         SPEED_INIT = 2,
   parameter int         SPEED_MAX  = 8,
   parameter int         SPEED_STEP = 4,
   parameter int         LIVES_INIT = 3,
   parameter int         HIT_FRAMES = 60,
   parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       pixel_overlap,
   output logic [9:0] xpos_obs,
   output logic [9:0] ypos_obs,
   output logic       move_en,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [1:0] state,
   output logic       flash
);

   localparam int                HC_W        = $clog2(HIT_FRAMES);
   localparam logic [HC_W-1:0]   HIT_CNT_TOP = HC_W'(HIT_FRAMES - 1);
   localparam logic [3:0]        SPEED_RST   = 4'(SPEED_INIT);
   localparam logic [3:0]        SPEED_CEIL  = 4'(SPEED_MAX);
   localparam logic [7:0]        STEP_MASK   = 8'(SPEED_STEP - 1);
   localparam logic [1:0]        LIVES_RST   = 2'(LIVES_INIT);
   localparam logic [9:0]        Y_SPAWN     = 10'(V_MIN);
   localparam logic [10:0]       Y_LIMIT     = 11'(V_MAX);

   state_t          st;
   logic [3:0]      speed;
   logic            hit_latch;
   logic [HC_W-1:0] hit_cnt;
   logic [9:0]      spawn_x;

   logic [10:0]     y_next;
   logic [7:0]      score_inc;
   logic            score_sat;
   logic            ramp;
   logic            hit_now;
   logic [HC_W-1:0] hit_cnt_dec;

   obs_spawn_lfsr #(
      .LFSR_SEED (LFSR_SEED)
   ) u_spawn (
      .clk     (clk),
      .rst     (rst),
      .adv     (frame_tick),
      .spawn_x (spawn_x)
   );

   // Fall step computed one bit wider so a step past the bottom edge cannot wrap.
   assign y_next      = {1'b0, ypos_obs} + {7'd0, speed};
   assign score_sat   = (score == 8'hFF);
   assign score_inc   = score + 8'd1;
   // Ramp only on a real increment landing on a multiple of the step size.
   assign ramp        = !score_sat && ((score_inc & STEP_MASK) == 8'd0) && (speed < SPEED_CEIL);
   // An overlap on the tick cycle itself belongs to the frame being closed.
   assign hit_now     = hit_latch | pixel_overlap;
   assign hit_cnt_dec = hit_cnt - HC_W'(1);

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         xpos_obs  <= X_RESET;
         ypos_obs  <= Y_SPAWN;
         score     <= 8'd0;
         lives     <= LIVES_RST;
         speed     <= SPEED_RST;
         hit_latch <= 1'b0;
         hit_cnt   <= '0;
         move_en   <= 1'b0;
         flash     <= 1'b0;
      end else begin
         case (st)
            // Start from IDLE or OVER opens a fresh round; a coincident tick
            // applies no motion, the transition takes the cycle.
            ST_IDLE, ST_OVER: begin
               if (start) begin
                  st        <= ST_PLAY;
                  score     <= 8'd0;
                  lives     <= LIVES_RST;
                  speed     <= SPEED_RST;
                  ypos_obs  <= Y_SPAWN;
                  hit_latch <= 1'b0;
                  move_en   <= 1'b1;
                  flash     <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  hit_latch <= 1'b0;
                  if (hit_now) begin
                     ypos_obs <= Y_SPAWN;
                     xpos_obs <= spawn_x;
                     move_en  <= 1'b0;
                     lives    <= lives - 2'd1;
                     if (lives == 2'd1) begin
                        st    <= ST_OVER;
                        flash <= 1'b1;
                     end else begin
                        st      <= ST_HIT;
                        hit_cnt <= HIT_CNT_TOP;
                        flash   <= HIT_CNT_TOP[3];
                     end
                  end else if (y_next > Y_LIMIT) begin
                     ypos_obs <= Y_SPAWN;
                     xpos_obs <= spawn_x;
                     if (!score_sat) begin
                        score <= score_inc;
                     end
                     if (ramp) begin
                        speed <= speed + 4'd1;
                     end
                  end else begin
                     ypos_obs <= y_next[9:0];
                  end
               end else begin
                  hit_latch <= hit_latch | pixel_overlap;
               end
            end
            ST_HIT: begin
               hit_latch <= 1'b0;
               if (frame_tick) begin
                  if (hit_cnt == '0) begin
                     st      <= ST_PLAY;
                     move_en <= 1'b1;
                     flash   <= 1'b0;
                  end else begin
                     hit_cnt <= hit_cnt_dec;
                     flash   <= hit_cnt_dec[3];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst, frame_tick, start, pixel_overlap;
   logic [9:0] xpos_obs, ypos_obs;
   logic       move_en, flash;
   logic [7:0] score;
   logic [1:0] lives, state;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model of the game rules (plain integers, one step per clock).
   int m_state, m_x, m_y, m_score, m_lives, m_speed, m_hc, m_lfsr;
   bit m_hl;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .frame_tick    (frame_tick),
      .start         (start),
      .pixel_overlap (pixel_overlap),
      .xpos_obs      (xpos_obs),
      .ypos_obs      (ypos_obs),
      .move_en       (move_en),
      .score         (score),
      .lives         (lives),
      .state         (state),
      .flash         (flash)
   );

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Spawn centre: left screen edge plus half-width, plus (lfsr mod 512) folded into 0..399.
   function automatic int spawn_of(input int l);
      return 264 + ((l % 512) % 400);
   endfunction

   // One step of x^10+x^7+1 in right-shifting Galois form.
   function automatic int lfsr_step(input int l);
      return (l / 2) ^ (((l % 2) == 1) ? 'h240 : 0);
   endfunction

   function automatic bit m_move();
      return m_state == 1;
   endfunction

   function automatic bit m_flash();
      return (m_state == 3) || (m_state == 2 && ((m_hc / 8) % 2 == 1));
   endfunction

   task automatic model_step(input bit r, input bit s, input bit t, input bit o);
      int sp;
      sp = spawn_of(m_lfsr);
      if (r) begin
         m_state = 0; m_x = 463; m_y = 35; m_score = 0; m_lives = 3;
         m_speed = 2; m_hl = 0; m_hc = 0; m_lfsr = 'h2A5;
         return;
      end
      if (t) m_lfsr = lfsr_step(m_lfsr);
      case (m_state)
         0, 3: if (s) begin
            m_state = 1; m_score = 0; m_lives = 3; m_speed = 2; m_y = 35; m_hl = 0;
         end
         1: if (t) begin
            if (m_hl || o) begin
               m_lives = m_lives - 1;
               m_y = 35; m_x = sp;
               if (m_lives == 0) m_state = 3;
               else begin m_state = 2; m_hc = 59; end
            end else if (m_y + m_speed > 515) begin
               m_y = 35; m_x = sp;
               if (m_score < 255) begin
                  m_score = m_score + 1;
                  if (m_score % 4 == 0 && m_speed < 8) m_speed = m_speed + 1;
               end
            end else begin
               m_y = m_y + m_speed;
            end
            m_hl = 0;
         end else if (o) begin
            m_hl = 1;
         end
         2: if (t) begin
            if (m_hc == 0) m_state = 1;
            else m_hc = m_hc - 1;
         end
         default: ;
      endcase
   endtask

   // Drive one clock of inputs (starting from a falling edge), step the model, return at the next falling edge.
   task automatic cyc(input bit r, input bit s, input bit t, input bit o);
      rst = r; start = s; frame_tick = t; pixel_overlap = o;
      @(posedge clk);
      model_step(r, s, t, o);
      @(negedge clk);
      rst = 1'b0; start = 1'b0; frame_tick = 1'b0; pixel_overlap = 1'b0;
   endtask

   // One frame: a mid-frame cycle, a random idle gap, then the frame_tick cycle.
   task automatic frame(input bit ov_mid, input bit ov_tick, input bit st_mid);
      int gap;
      cyc(1'b0, st_mid, 1'b0, ov_mid);
      gap = $urandom_range(0, 2);
      repeat (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, ov_tick);
   endtask

   // Clear obstacles until the model score reaches target; tracks the obstacle every frame.
   task automatic clear_until(input int target, input int budget, input string tag);
      int n;
      bit rs;
      n = 0;
      while (m_score < target && n < budget) begin
         rs = 1'($urandom_range(0, 1));
         frame(1'b0, 1'b0, rs);
         n++;
         n_cmp++;
         if (ypos_obs !== 10'(m_y) || xpos_obs !== 10'(m_x) || score !== 8'(m_score)) begin
            n_fail++;
            $display("FAIL %s_track: got y=%0d x=%0d score=%0d want y=%0d x=%0d score=%0d",
                     tag, ypos_obs, xpos_obs, score, m_y, m_x, m_score);
         end
      end
      if (m_score < target) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: score %0d after %0d frames, want %0d", tag, m_score, n, target);
      end
   endtask

   task automatic test_reset();
      bit ov;
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd0)    begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
      n_cmp++; if (xpos_obs !== 10'd463) begin n_fail++; $display("FAIL rst_x: got %0d want 463", xpos_obs); end
      n_cmp++; if (ypos_obs !== 10'd35)  begin n_fail++; $display("FAIL rst_y: got %0d want 35", ypos_obs); end
      n_cmp++; if (move_en !== 1'b0) begin n_fail++; $display("FAIL rst_move: got %0b want 0", move_en); end
      n_cmp++; if (lives !== 2'd3)   begin n_fail++; $display("FAIL rst_lives: got %0d want 3", lives); end
      n_cmp++; if (score !== 8'd0)   begin n_fail++; $display("FAIL rst_score: got %0d want 0", score); end
      n_cmp++; if (flash !== 1'b0)   begin n_fail++; $display("FAIL rst_flash: got %0b want 0", flash); end
      for (int i = 0; i < 10; i++) begin
         ov = 1'($urandom_range(0, 1));
         frame(ov, 1'b0, 1'b0);
      end
      n_cmp++; if (state !== 2'd0)    begin n_fail++; $display("FAIL idle_state: got %0d want 0", state); end
      n_cmp++; if (ypos_obs !== 10'd35)  begin n_fail++; $display("FAIL idle_y: got %0d want 35", ypos_obs); end
      n_cmp++; if (xpos_obs !== 10'd463) begin n_fail++; $display("FAIL idle_x: got %0d want 463", xpos_obs); end
      n_cmp++; if (move_en !== 1'b0) begin n_fail++; $display("FAIL idle_move: got %0b want 0", move_en); end
      n_cmp++; if (lives !== 2'd3)   begin n_fail++; $display("FAIL idle_lives: got %0d want 3", lives); end
   endtask

   task automatic test_fall();
      bit rs;
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
      n_cmp++; if (move_en !== 1'b1) begin n_fail++; $display("FAIL start_move: got %0b want 1", move_en); end
      for (int i = 0; i < 240; i++) begin
         rs = 1'($urandom_range(0, 1));
         frame(1'b0, 1'b0, rs);
         n_cmp++;
         if (ypos_obs !== 10'(m_y)) begin
            n_fail++; $display("FAIL fall_y: frame %0d got %0d want %0d", i, ypos_obs, m_y);
         end
      end
      n_cmp++; if (ypos_obs !== 10'd515) begin n_fail++; $display("FAIL fall_bottom: got %0d want 515", ypos_obs); end
      n_cmp++; if (score !== 8'd0) begin n_fail++; $display("FAIL fall_score0: got %0d want 0", score); end
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ypos_obs !== 10'd35) begin n_fail++; $display("FAIL respawn_y: got %0d want 35", ypos_obs); end
      n_cmp++; if (score !== 8'd1) begin n_fail++; $display("FAIL respawn_score: got %0d want 1", score); end
      n_cmp++;
      if (xpos_obs < 10'd264 || xpos_obs > 10'd663 || xpos_obs !== 10'(m_x)) begin
         n_fail++; $display("FAIL respawn_x: got %0d want %0d (264..663)", xpos_obs, m_x);
      end
   endtask

   task automatic test_speed_ramp();
      clear_until(4, 2000, "ramp4");
      n_cmp++; if (score !== 8'd4) begin n_fail++; $display("FAIL ramp_score4: got %0d want 4", score); end
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ypos_obs !== 10'd38) begin n_fail++; $display("FAIL ramp_speed3: got y=%0d want 38", ypos_obs); end
      clear_until(24, 6000, "ramp24");
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ypos_obs !== 10'd43) begin n_fail++; $display("FAIL ramp_speed8: got y=%0d want 43", ypos_obs); end
      clear_until(28, 2000, "ramp28");
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ypos_obs !== 10'd43) begin n_fail++; $display("FAIL ramp_cap: got y=%0d want 43", ypos_obs); end
   endtask

   task automatic test_hit();
      bit a, b, c;
      frame(1'b1, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd2) begin n_fail++; $display("FAIL hit_state: got %0d want 2", state); end
      n_cmp++; if (lives !== 2'd2) begin n_fail++; $display("FAIL hit_lives: got %0d want 2", lives); end
      n_cmp++; if (ypos_obs !== 10'd35) begin n_fail++; $display("FAIL hit_y: got %0d want 35", ypos_obs); end
      n_cmp++; if (move_en !== 1'b0) begin n_fail++; $display("FAIL hit_move: got %0b want 0", move_en); end
      n_cmp++; if (flash !== 1'b1) begin n_fail++; $display("FAIL hit_flash0: got %0b want 1", flash); end
      n_cmp++; if (xpos_obs !== 10'(m_x)) begin n_fail++; $display("FAIL hit_x: got %0d want %0d", xpos_obs, m_x); end
      for (int i = 0; i < 59; i++) begin
         a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
         frame(a, b, c);
         n_cmp++;
         if (state !== 2'd2 || lives !== 2'd2 || flash !== m_flash() || ypos_obs !== 10'd35) begin
            n_fail++;
            $display("FAIL hit_hold: frame %0d got st=%0d lives=%0d flash=%0b y=%0d want st=2 lives=2 flash=%0b y=35",
                     i, state, lives, flash, ypos_obs, m_flash());
         end
      end
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL hit_exit: got %0d want 1", state); end
      n_cmp++; if (move_en !== 1'b1) begin n_fail++; $display("FAIL hit_exit_move: got %0b want 1", move_en); end
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (state !== 2'd1 || lives !== 2'd2 || ypos_obs !== 10'(m_y)) begin
         n_fail++; $display("FAIL hit_noghost: got st=%0d lives=%0d y=%0d want st=1 lives=2 y=%0d", state, lives, ypos_obs, m_y);
      end
   endtask

   task automatic test_game_over();
      bit ov;
      frame(1'b0, 1'b1, 1'b0);
      n_cmp++; if (state !== 2'd2 || lives !== 2'd1) begin
         n_fail++; $display("FAIL tick_overlap: got st=%0d lives=%0d want st=2 lives=1", state, lives);
      end
      repeat (60) frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd1) begin n_fail++; $display("FAIL hit2_exit: got %0d want 1", state); end
      frame(1'b1, 1'b1, 1'b0);
      n_cmp++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_state: got %0d want 3", state); end
      n_cmp++; if (lives !== 2'd0) begin n_fail++; $display("FAIL over_lives: got %0d want 0", lives); end
      n_cmp++; if (flash !== 1'b1) begin n_fail++; $display("FAIL over_flash: got %0b want 1", flash); end
      n_cmp++; if (move_en !== 1'b0) begin n_fail++; $display("FAIL over_move: got %0b want 0", move_en); end
      for (int i = 0; i < 5; i++) begin
         ov = 1'($urandom_range(0, 1));
         frame(ov, ov, 1'b0);
      end
      n_cmp++;
      if (state !== 2'd3 || score !== 8'(m_score) || lives !== 2'd0 || ypos_obs !== 10'd35) begin
         n_fail++; $display("FAIL over_hold: got st=%0d score=%0d lives=%0d y=%0d want st=3 score=%0d lives=0 y=35",
                            state, score, lives, ypos_obs, m_score);
      end
      // Start and tick in the same cycle: transition only, no fall step.
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (state !== 2'd1 || score !== 8'd0 || lives !== 2'd3 || ypos_obs !== 10'd35 || move_en !== 1'b1) begin
         n_fail++; $display("FAIL restart: got st=%0d score=%0d lives=%0d y=%0d move=%0b want 1/0/3/35/1",
                            state, score, lives, ypos_obs, move_en);
      end
      frame(1'b0, 1'b0, 1'b0);
      n_cmp++; if (ypos_obs !== 10'd37) begin n_fail++; $display("FAIL restart_speed: got y=%0d want 37", ypos_obs); end
   endtask

   task automatic test_reset_mid();
      clear_until(7, 3000, "pre_rst");
      frame(1'b1, 1'b0, 1'b0);
      n_cmp++; if (state !== 2'd2 || score !== 8'd7) begin
         n_fail++; $display("FAIL pre_rst_hit: got st=%0d score=%0d want st=2 score=7", state, score);
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      n_cmp++;
      if (state !== 2'd0 || score !== 8'd0 || lives !== 2'd3 || xpos_obs !== 10'd463 ||
          ypos_obs !== 10'd35 || move_en !== 1'b0 || flash !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst: got st=%0d score=%0d lives=%0d x=%0d y=%0d move=%0b flash=%0b",
                            state, score, lives, xpos_obs, ypos_obs, move_en, flash);
      end
      // First spawn after reset comes straight from the seed 10'h2A5: 264 + 165.
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      frame(1'b1, 1'b0, 1'b0);
      n_cmp++; if (xpos_obs !== 10'd429) begin n_fail++; $display("FAIL seed_spawn: got x=%0d want 429", xpos_obs); end
      n_cmp++; if (state !== 2'd2 || lives !== 2'd2) begin
         n_fail++; $display("FAIL seed_hit: got st=%0d lives=%0d want st=2 lives=2", state, lives);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; frame_tick = 1'b0; pixel_overlap = 1'b0;
      m_state = 0; m_x = 0; m_y = 0; m_score = 0; m_lives = 0; m_speed = 0; m_hc = 0; m_lfsr = 0; m_hl = 0;
      @(negedge clk);
      test_reset();
      test_fall();
      test_speed_ramp();
      test_hit();
      test_game_over();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Game-level controller for the block/obstacle datapath. Sequences the round (idle, play, hit recovery, game over).
- Owns obstacle position: falling motion, respawn, pseudo-random x placement, speed ramp.
- Detects player/obstacle collision from the per-pixel overlap flag. Keeps score and lives.
- Gates player movement via move_en. Drives obstacle centre coordinates and status to the pixel/colour logic.

Parameters:
- H_MIN, 144, first visible hCount
- H_MAX, 783, last visible hCount
- V_MIN, 35, first visible vCount; obstacle spawn row
- V_MAX, 515, last visible vCount
- OBS_HALF_W, 120, obstacle half-width; bounds spawn x
- SPEED_INIT, 2, initial fall step (pixels/frame)
- SPEED_MAX, 8, fall step ceiling
- SPEED_STEP, 4, obstacles cleared per speed increment (power of two)
- LIVES_INIT, 3, lives at round start (1..3)
- HIT_FRAMES, 60, frames of hit recovery
- LFSR_SEED, 10'h2A5, nonzero LFSR reset value

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blanking
- start  in  1  one-cycle debounced start-button pulse
- pixel_overlap  in  1  high on cycles where block_fill && obs_fill && bright
- xpos_obs  out  10  obstacle centre x
- ypos_obs  out  10  obstacle centre y
- move_en  out  1  player block may move
- score  out  8  obstacles cleared, saturating at 255
- lives  out  2  remaining lives
- state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3
- flash  out  1  blink request for colour logic

Behaviour:
- Reset (rst high at posedge, overrides everything, including mid-round):
  - state=IDLE, xpos_obs=463, ypos_obs=V_MIN
  - score=0, lives=LIVES_INIT, speed=SPEED_INIT
  - hit_latch=0, hit_cnt=0, lfsr=LFSR_SEED
  - move_en=0, flash=0
- All outputs are registered; each update is visible the cycle after the causing edge.
- LFSR:
  - 10-bit Galois, polynomial x^10+x^7+1.
  - Advances on every frame_tick in every state; never reaches 0.
- Spawn x:
  - c = lfsr[8:0]; if c>=400 then c -= 400.
  - xpos_obs = H_MIN+OBS_HALF_W+c, giving range 264..663, so the obstacle stays fully on screen.
- Round init (start accepted): score=0, lives=LIVES_INIT, speed=SPEED_INIT, ypos_obs=V_MIN, hit_latch=0.
- IDLE:
  - move_en=0, flash=0, obstacle frozen.
  - start -> PLAY with round init.
- PLAY:
  - move_en=1.
  - hit_latch is set by any pixel_overlap cycle.
  - On frame_tick, with hit = hit_latch | pixel_overlap (an overlap coincident with the tick belongs to the closing frame):
    - If hit:
      - lives -= 1.
      - If lives was 1 -> OVER (lives=0). Otherwise -> HIT with hit_cnt=HIT_FRAMES-1.
      - In both cases ypos_obs=V_MIN and xpos_obs=new spawn x.
    - Else:
      - next = ypos_obs+speed, computed in 11 bits.
      - If next > V_MAX: respawn (ypos_obs=V_MIN, new spawn x) and score += 1, saturating.
      - When the new score is a multiple of SPEED_STEP and speed < SPEED_MAX: speed += 1.
      - Otherwise ypos_obs = next.
    - hit_latch is cleared on every frame_tick.
  - start is ignored.
- HIT:
  - move_en=0, flash=hit_cnt[3], obstacle frozen, pixel_overlap ignored, hit_latch held 0, start ignored.
  - On frame_tick: if hit_cnt==0 -> PLAY, else hit_cnt -= 1.
- OVER:
  - move_en=0, flash=1, obstacle frozen, score and lives hold.
  - start -> PLAY with round init.
- start and frame_tick in the same cycle: the state transition wins; no motion is applied that cycle; the LFSR still advances.
- speed is 4 bits and never exceeds SPEED_MAX. The score saturates; the speed ramp stops at saturation.

Decomposition:
- Package game_pkg holds:
  - state encoding constants
  - screen bounds (144/783/35/515)
  - colour constants shared with the colour logic
- One sub-module, obs_spawn_lfsr: LFSR plus the spawn-x mapping.
  - Inputs: clk, rst, adv.
  - Output: spawn_x (10 bits).

Test Plan:
1. Reset, no start, 10 frame_ticks -> state=0, ypos_obs=35, xpos_obs=463, move_en=0, lives=3.
2. start, then 240 frame_ticks -> ypos_obs=515, score=0. Tick 241 -> ypos_obs=35, score=1, xpos_obs in 264..663.
3. Clear 4 obstacles -> score=4, speed=3, next tick ypos_obs=38. After 24 clears, speed holds at 8.
4. Single pixel_overlap pulse mid-frame, then frame_tick -> state=2, lives=2, ypos_obs=35, move_en=0. After 60 more ticks -> state=1. Overlap during HIT leaves lives unchanged.
5. Third hit -> state=3, lives=0, flash=1. Then start -> state=1, score=0, lives=3, speed=2. pixel_overlap coincident with frame_tick counts as a hit.
6. rst asserted while in HIT with score=7 -> next cycle: all reset values, state=0, lfsr=10'h2A5.
